fault_diagnoser: RTL



---
 rtl/fault_diag_pkg.sv | 24 ++
 rtl/syndrome_popcount.sv | 35 +++
 rtl/fault_diagnoser.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fault_diag_pkg.sv
// Shared parameters, FSM state encoding and dictionary entry type for the
// fault diagnoser.
package fault_diag_pkg;

   localparam int unsigned TEST_COUNT = 60;
   localparam int unsigned OUT_WIDTH  = 32;
   localparam int unsigned ID_WIDTH   = 13;
   localparam int unsigned DIST_WIDTH = 6;
   localparam int unsigned CNT_WIDTH  = $clog2(TEST_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      SCAN    = 2'd2,
      DONE    = 2'd3
   } diag_state_e;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [TEST_COUNT-1:0] syndrome;
      logic                  last;
   } dict_entry_t;

endpackage

// File: rtl/syndrome_popcount.sv
// Combinational population count built as a balanced binary adder tree.
// The input is padded to the next power of two with zero leaves; node 0 is
// the root. Partial sums never exceed W, so CW bits suffice at every level.
module syndrome_popcount
   import fault_diag_pkg::*;
#(
   parameter int unsigned W  = TEST_COUNT,
   parameter int unsigned CW = DIST_WIDTH
) (
   input  logic [W-1:0]  in_i,
   output logic [CW-1:0] count_o
);

   localparam int unsigned LEVELS = $clog2(W);
   localparam int unsigned PAD    = 1 << LEVELS;

   logic [CW-1:0] node_s [0:2*PAD-2];

   genvar gi;
   generate
      for (gi = 0; gi < PAD; gi++) begin : g_leaf
         if (gi < W) begin : g_bit
            assign node_s[PAD-1+gi] = {{(CW-1){1'b0}}, in_i[gi]};
         end else begin : g_pad
            assign node_s[PAD-1+gi] = {CW{1'b0}};
         end
      end
      for (gi = 0; gi < PAD-1; gi++) begin : g_sum
         assign node_s[gi] = node_s[2*gi+1] + node_s[2*gi+2];
      end
   endgenerate

   assign count_o = node_s[0];

endmodule

// File: rtl/fault_diagnoser.sv
// Builds the observed syndrome from golden/observed response comparisons,
// then streams a fault dictionary and keeps the earliest minimum-Hamming-
// distance entry together with a saturating exact-match count.
module fault_diagnoser
   import fault_diag_pkg::*;
#(
   parameter int unsigned ID_W = ID_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  resp_valid_i,
   input  logic [OUT_WIDTH-1:0]  resp_golden_i,
   input  logic [OUT_WIDTH-1:0]  resp_observed_i,
   input  logic                  dict_valid_i,
   output logic                  dict_ready_o,
   input  logic [ID_W-1:0]       dict_id_i,
   input  logic [TEST_COUNT-1:0] dict_syndrome_i,
   input  logic                  dict_last_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [TEST_COUNT-1:0] syndrome_o,
   output logic                  fault_free_o,
   output logic [ID_W-1:0]       best_id_o,
   output logic [DIST_WIDTH-1:0] best_dist_o,
   output logic [ID_W-1:0]       match_count_o
);

   diag_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [TEST_COUNT-1:0] syndrome_q, syndrome_d;
   logic                  fault_free_q, fault_free_d;
   logic [ID_W-1:0]       best_id_q, best_id_d;
   logic [DIST_WIDTH-1:0] best_dist_q, best_dist_d;
   logic [ID_W-1:0]       match_q, match_d;
   logic                  have_best_q, have_best_d;

   logic [DIST_WIDTH-1:0] dist_s;
   logic                  accept_s;
   logic                  mismatch_s;
   logic                  last_resp_s;

   syndrome_popcount #(.W(TEST_COUNT), .CW(DIST_WIDTH)) u_popcount (
      .in_i    (dict_syndrome_i ^ syndrome_q),
      .count_o (dist_s)
   );

   assign accept_s    = (state_q == SCAN) && dict_valid_i;
   assign mismatch_s  = (resp_golden_i != resp_observed_i);
   assign last_resp_s = (cnt_q == CNT_WIDTH'(TEST_COUNT - 1));

   assign dict_ready_o  = (state_q == SCAN);
   assign busy_o        = (state_q == COLLECT) || (state_q == SCAN);
   assign done_o        = (state_q == DONE);
   assign syndrome_o    = syndrome_q;
   assign fault_free_o  = fault_free_q;
   assign best_id_o     = best_id_q;
   assign best_dist_o   = best_dist_q;
   assign match_count_o = match_q;

   // Next-state logic: start restarts from any state; otherwise collect
   // responses, then score each accepted dictionary entry.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      syndrome_d   = syndrome_q;
      fault_free_d = fault_free_q;
      best_id_d    = best_id_q;
      best_dist_d  = best_dist_q;
      match_d      = match_q;
      have_best_d  = have_best_q;

      if (start_i) begin
         state_d      = COLLECT;
         cnt_d        = '0;
         syndrome_d   = '0;
         fault_free_d = 1'b0;
         best_id_d    = '0;
         best_dist_d  = '0;
         match_d      = '0;
         have_best_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            COLLECT: begin
               if (resp_valid_i) begin
                  syndrome_d[cnt_q] = mismatch_s;
                  if (last_resp_s) begin
                     state_d      = SCAN;
                     cnt_d        = '0;
                     fault_free_d = (syndrome_d == '0);
                  end else begin
                     cnt_d = cnt_q + CNT_WIDTH'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            SCAN: begin
               if (accept_s) begin
                  have_best_d = 1'b1;
                  // Strict less-than keeps the earliest entry on ties.
                  if (!have_best_q || (dist_s < best_dist_q)) begin
                     best_id_d   = dict_id_i;
                     best_dist_d = dist_s;
                  end else begin
                     best_id_d   = best_id_q;
                     best_dist_d = best_dist_q;
                  end
                  if ((dist_s == '0) && (match_q != {ID_W{1'b1}})) begin
                     match_d = match_q + ID_W'(1);
                  end else begin
                     match_d = match_q;
                  end
                  if (dict_last_i) begin
                     state_d = DONE;
                  end else begin
                     state_d = SCAN;
                  end
               end else begin
                  state_d = SCAN;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         syndrome_q   <= '0;
         fault_free_q <= 1'b0;
         best_id_q    <= '0;
         best_dist_q  <= '0;
         match_q      <= '0;
         have_best_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         syndrome_q   <= syndrome_d;
         fault_free_q <= fault_free_d;
         best_id_q    <= best_id_d;
         best_dist_q  <= best_dist_d;
         match_q      <= match_d;
         have_best_q  <= have_best_d;
      end
   end

endmodule
